bram_stream_reader: RTL and testbench

//  Read-side master for a single-port block RAM with 1-cycle read latency.
//  On a start command, reads len consecutive words from base_addr and streams them out on a

---
 rtl/bram_rd_pkg.sv | 15 +
 rtl/bram_rd_skid.sv | 85 ++++++++
 rtl/bram_stream_reader.sv | 121 ++++++++++++
 tb/tb_bram_stream_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM stream reader.
//   state_t    : reader FSM encoding
//   SKID_DEPTH : number of words the output skid buffer can hold
package bram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry skid FIFO holding {last, data} words returned by the BRAM.
// The head entry is a register, so the stream outputs are registered.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_push            write i_push_data/i_push_last this cycle
//   i_push_data       word to store
//   i_push_last       last-word tag to store
//   i_pop             consumer takes the head (ignored when empty)
//   o_occ             number of stored entries (0..2)
//   o_head_valid      head entry present
//   o_head_data       head data
//   o_head_last       head last-word tag
module bram_rd_skid #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_push_last,
    input  logic              i_pop,
    output logic [1:0]        o_occ,
    output logic              o_head_valid,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_head_last
);

    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_last0;
    logic              r_last1;
    logic [1:0]        r_occ;
    logic              w_pop;

    assign w_pop = i_pop && (r_occ != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_occ   <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                        r_occ   <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                        r_occ   <= 2'd2;
                    end
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Upstream credit logic keeps this to occ==1; the occ==2
                    // branch just keeps ordering sane if it ever happened.
                    if (r_occ == 2'd1) begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ        = r_occ;
    assign o_head_valid = (r_occ != 2'd0);
    assign o_head_data  = r_data0;
    assign o_head_last  = r_last0;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads len consecutive words from a 1-cycle-latency single-port BRAM starting
// at base_addr and streams them out on a valid/ready interface with last flag.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | issuing BRAM reads, throttled by skid credit
// DRAIN  | all reads issued, waiting for the last word handshake
// DONE   | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_start, i_base_addr, i_len  command (sampled only in IDLE)
//   o_busy, o_done             status
//   o_mem_en/we/addr, i_mem_dout  BRAM read port
//   o_m_data/valid/last, i_m_ready  output stream
module bram_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic              o_m_last
);
    import bram_rd_pkg::*;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [1:0]        w_occ;
    logic              w_head_valid;
    logic              w_head_last;
    logic [DATA_W-1:0] w_head_data;
    logic              w_pop;
    logic              w_issue;
    logic              w_last_issue;
    logic [2:0]        w_credit;
    logic [2:0]        w_limit;

    assign w_pop        = w_head_valid && i_m_ready;
    // occ + inflight - pop < DEPTH, rearranged to avoid unsigned underflow.
    assign w_credit     = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_limit      = 3'(SKID_DEPTH) + {2'b00, w_pop};
    assign w_issue      = (r_state == ST_READ) && (w_credit < w_limit);
    assign w_last_issue = (r_issued == (r_len - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_issue;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr   <= i_base_addr;
                        r_len    <= i_len;
                        r_issued <= '0;
                        r_state  <= (i_len != '0) ? ST_READ : ST_DONE;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_issued <= r_issued + LEN_W'(1);
                        if (w_last_issue) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_head_last) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    bram_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (r_inflight),
        .i_push_data  (i_mem_dout),
        .i_push_last  (r_inflight_last),
        .i_pop        (w_pop),
        .o_occ        (w_occ),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data),
        .o_head_last  (w_head_last)
    );

    assign o_busy     = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign o_done     = (r_state == ST_DONE);
    assign o_mem_en   = w_issue;
    assign o_mem_we   = 1'b0;
    assign o_mem_addr = r_addr;
    assign o_m_data   = w_head_data;
    assign o_m_valid  = w_head_valid;
    assign o_m_last   = w_head_valid && w_head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [LEN_W-1:0]  i_len = '0;
    logic              o_busy, o_done, o_mem_en, o_mem_we, o_m_valid, o_m_last;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] i_mem_dout = '0;
    logic [DATA_W-1:0] o_m_data;
    logic              i_m_ready = 1'b1;

    bram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .i_mem_dout  (i_mem_dout),
        .o_m_data    (o_m_data),
        .o_m_valid   (o_m_valid),
        .i_m_ready   (i_m_ready),
        .o_m_last    (o_m_last)
    );

    always #5 clk = ~clk;

    // BRAM model: each word holds its own address.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    initial for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = DATA_W'(a);
    always @(posedge clk) if (o_mem_en) i_mem_dout <= mem[o_mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard queues: {last, data} for the stream, addresses for the BRAM port.
    logic [DATA_W:0]   exp_q [$];
    logic [ADDR_W-1:0] addr_q[$];

    int s_cyc = 0;
    int last_hs_cyc = 0;
    int en_cnt = 0;
    bit pending_first = 0;
    bit cur_len_zero = 0;
    bit busy_seen = 0;
    bit tog_en = 0;
    int tog_idx = 0;

    // Independent view of skid occupancy, derived from observed issues and pops.
    int occ_m = 0;
    int inf_m = 0;
    bit prev_stall = 0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            case (tog_idx % 4)
                0, 3:    i_m_ready = 1'b1;
                default: i_m_ready = 1'b0;
            endcase
            tog_idx++;
        end
    end

    always @(negedge clk) begin
        int pop;
        logic [DATA_W:0] e;
        if (!rst_n) begin
            occ_m = 0;
            inf_m = 0;
            prev_stall = 0;
        end else begin
            pop = (o_m_valid && i_m_ready) ? 1 : 0;
            busy_seen |= o_busy;
            if (o_m_valid != (occ_m != 0)) chk("skid_valid", int'(o_m_valid), int'(occ_m != 0));
            if (o_m_last && !o_m_valid) fail_now("last_without_valid");
            if (o_mem_en) begin
                en_cnt++;
                chk("issue_rule", int'(occ_m + inf_m - pop < 2), 1);
                if (addr_q.size() == 0) fail_now("unexpected_mem_en");
                else chk("mem_addr", int'(o_mem_addr), int'(addr_q.pop_front()));
            end
            if (prev_stall) begin
                chk("stall_valid", int'(o_m_valid), 1);
                chk("stall_data", int'(o_m_data), int'(prev_data));
            end
            if (o_m_valid && pending_first) begin
                chk("first_valid_latency", cyc - s_cyc, 3);
                pending_first = 0;
            end
            if (pop == 1) begin
                if (exp_q.size() == 0) fail_now("unexpected_word");
                else begin
                    e = exp_q.pop_front();
                    chk("m_data", int'(o_m_data), int'(e[DATA_W-1:0]));
                    chk("m_last", int'(o_m_last), int'(e[DATA_W]));
                    if (o_m_last) last_hs_cyc = cyc;
                end
            end
            if (o_done) begin
                if (o_busy) fail_now("busy_with_done");
                if (cur_len_zero) chk("done_latency_len0", cyc - s_cyc, 1);
                else chk("done_after_last", cyc - last_hs_cyc, 1);
            end
            occ_m = occ_m + inf_m - pop;
            inf_m = o_mem_en ? 1 : 0;
            prev_stall = o_m_valid && !i_m_ready;
            prev_data = o_m_data;
        end
    end

    task automatic issue_start(input int base, input int len);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_base_addr = ADDR_W'(base);
        i_len = LEN_W'(len);
        s_cyc = cyc;
        en_cnt = 0;
        busy_seen = 0;
        cur_len_zero = (len == 0);
        pending_first = (len != 0);
        for (int i = 0; i < len; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(base + i);
            addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), DATA_W'(a)});
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int exp_en);
        bit got;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (o_done) got = 1;
        end
        if (!got) fail_now("done_timeout");
        @(negedge clk);
        chk("mem_en_count", en_cnt, exp_en);
        chk("words_left", exp_q.size(), 0);
        chk("busy_after_done", int'(o_busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_mem_en", int'(o_mem_en), 0);
        chk("rst_mem_we", int'(o_mem_we), 0);
        chk("rst_mem_addr", int'(o_mem_addr), 0);
        chk("rst_m_valid", int'(o_m_valid), 0);
        chk("rst_m_last", int'(o_m_last), 0);
        chk("rst_m_data", int'(o_m_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: basic streaming at full rate
        issue_start('h010, 4);
        wait_done(4);

        // 2: address wrap
        issue_start('h3FE, 4);
        wait_done(4);

        // 3: backpressure pattern 1-0-0-1
        tog_idx = 0;
        tog_en = 1;
        issue_start('h200, 8);
        wait_done(8);
        tog_en = 0;
        @(negedge clk);
        i_m_ready = 1'b1;

        // 4: zero length
        issue_start(0, 0);
        wait_done(0);
        chk("len0_busy_seen", int'(busy_seen), 0);

        // 5: start during transfer is ignored
        issue_start('h050, 6);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_base_addr = ADDR_W'('h300);
        i_len = LEN_W'(2);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(6);

        // 6: reset with a full skid, then a clean transfer
        i_m_ready = 1'b0;
        issue_start('h080, 6);
        begin
            bit full;
            full = 0;
            for (int i = 0; i < 20 && !full; i++) begin
                @(negedge clk);
                #1;
                if (occ_m == 2) full = 1;
            end
            chk("skid_filled", int'(full), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_mem_en", int'(o_mem_en), 0);
        chk("mid_rst_mem_addr", int'(o_mem_addr), 0);
        chk("mid_rst_m_valid", int'(o_m_valid), 0);
        chk("mid_rst_m_last", int'(o_m_last), 0);
        chk("mid_rst_m_data", int'(o_m_data), 0);
        chk("mid_rst_done", int'(o_done), 0);
        exp_q.delete();
        addr_q.delete();
        pending_first = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        i_m_ready = 1'b1;
        repeat (4) @(posedge clk);
        issue_start('h100, 2);
        wait_done(2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
